// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan PWM driver: FSM states, duty code type
// and the saturating ramp step.
package fan_pkg;

   localparam int unsigned DUTY_W = 8;

   typedef logic [DUTY_W-1:0] duty_t;

   localparam duty_t PWM_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KICK = 2'd1,
      RAMP = 2'd2,
      HOLD = 2'd3
   } fan_state_t;

   // One ramp step from cur toward tgt, landing exactly on tgt when closer than step
   function automatic duty_t ramp_toward(input duty_t cur, input duty_t tgt, input duty_t step);
      duty_t gap;
      ramp_toward = cur;
      gap         = '0;
      if (cur < tgt) begin
         gap         = tgt - cur;
         ramp_toward = (gap <= step) ? tgt : duty_t'(cur + step);
      end else if (cur > tgt) begin
         gap         = cur - tgt;
         ramp_toward = (gap <= step) ? tgt : duty_t'(cur - step);
      end
   endfunction

endpackage

// File: rtl/fan_pwm_driver_pwm_gen.sv
// Free-running 8-bit PWM period counter and duty comparator with a
// period-boundary strobe on the last count of each period.
module pwm_gen
   import fan_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] duty,
   output logic       PWM,
   output logic       boundary_c
);

   duty_t cnt;

   // Full-scale duty is held high so the gate never blips low at wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         PWM <= 1'b0;
      end else begin
         cnt <= cnt + 8'd1;
         PWM <= (duty == PWM_MAX) || (cnt < duty);
      end
   end

   assign boundary_c = (cnt == PWM_MAX);

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: decodes F1/F2 into a duty target and slews the applied duty
// toward it once per PWM period. Optional kick-start via FAN_KICKSTART_EN.
module fan_pwm_driver
   import fan_pkg::*;
#(
   parameter int unsigned LOW_DUTY     = 96,
   parameter int unsigned HIGH_DUTY    = 255,
   parameter int unsigned RAMP_STEP    = 8,
   parameter int unsigned KICK_PERIODS = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       F1,
   input  logic       F2,
   output logic       PWM,
   output logic [7:0] DUTY,
   output logic       BUSY,
   output logic       AT_SPEED
);

   localparam duty_t LOW_CODE  = 8'(LOW_DUTY);
   localparam duty_t HIGH_CODE = 8'(HIGH_DUTY);
   localparam duty_t STEP_CODE = 8'(RAMP_STEP);

   logic       f1_q;
   logic       f2_q;
   logic       boundary_c;
   duty_t      target_c;
   duty_t      step_c;
   duty_t      duty_q;
   duty_t      duty_d;
   fan_state_t state_q;
   fan_state_t state_d;
   fan_state_t settle_c;

`ifdef FAN_KICKSTART_EN
   localparam int unsigned KICK_W = 8;

   logic [KICK_W-1:0] kick_q;
   logic [KICK_W-1:0] kick_d;
   logic              kick_done_c;

   assign kick_done_c = (32'(kick_q) + 32'd1) >= KICK_PERIODS;
`endif

   // Single input register stage; every decision uses these copies
   always_ff @(posedge clk) begin
      if (rst) begin
         f1_q <= 1'b0;
         f2_q <= 1'b0;
      end else begin
         f1_q <= F1;
         f2_q <= F2;
      end
   end

   // F2 dominates F1
   always_comb begin
      target_c = '0;
      if (f2_q) begin
         target_c = HIGH_CODE;
      end else if (f1_q) begin
         target_c = LOW_CODE;
      end
   end

   // Where one ramp step lands and which state that leaves us in
   always_comb begin
      step_c   = ramp_toward(duty_q, target_c, STEP_CODE);
      settle_c = RAMP;
      if (step_c == target_c) begin
         settle_c = (target_c == '0) ? IDLE : HOLD;
      end
   end

   pwm_gen u_pwm_gen (
      .clk        (clk),
      .rst        (rst),
      .duty       (duty_q),
      .PWM        (PWM),
      .boundary_c (boundary_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         duty_q   <= '0;
         BUSY     <= 1'b0;
         AT_SPEED <= 1'b0;
`ifdef FAN_KICKSTART_EN
         kick_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         BUSY     <= (state_d == KICK) || (state_d == RAMP);
         AT_SPEED <= (duty_d == target_c) && (target_c != '0);
`ifdef FAN_KICKSTART_EN
         kick_q   <= kick_d;
`endif
      end
   end

   // Duty only moves on a period boundary so no PWM period is cut short
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
`ifdef FAN_KICKSTART_EN
      kick_d  = kick_q;
`endif
      case (state_q)
         IDLE: begin
            if (boundary_c && (target_c != '0)) begin
`ifdef FAN_KICKSTART_EN
               state_d = KICK;
               duty_d  = PWM_MAX;
               kick_d  = '0;
`else
               state_d = settle_c;
               duty_d  = step_c;
`endif
            end
         end
`ifdef FAN_KICKSTART_EN
         KICK: begin
            // A dropped request abandons the kick at once and ramps down from full
            if (target_c == '0) begin
               state_d = RAMP;
               kick_d  = '0;
            end else if (boundary_c) begin
               if (kick_done_c) begin
                  state_d = settle_c;
                  duty_d  = step_c;
                  kick_d  = '0;
               end else begin
                  kick_d  = kick_q + 8'd1;
               end
            end
         end
`endif
         RAMP, HOLD: begin
            if (boundary_c) begin
               state_d = settle_c;
               duty_d  = step_c;
            end
         end
         default: begin
            state_d = IDLE;
            duty_d  = '0;
         end
      endcase
   end

   assign DUTY = duty_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Bench for fan_pwm_driver: period-level reference model plus directed scenarios
// and randomized F1/F2 activity.
module tb_fan_pwm_driver;

   localparam int LOW   = 96;
   localparam int HIGH  = 255;
   localparam int STEP  = 8;
   localparam int KICKP = 4;
`ifdef FAN_KICKSTART_EN
   localparam bit KICK_EN = 1'b1;
`else
   localparam bit KICK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       F1  = 1'b0;
   logic       F2  = 1'b0;
   logic       PWM;
   logic [7:0] DUTY;
   logic       BUSY;
   logic       AT_SPEED;

   int tests = 0;
   int fails = 0;

   // reference model
   int m_cnt  = 0;
   int m_duty = 0;
   int m_kick = 0;
   bit m_pwm  = 1'b0;
   bit m_busy = 1'b0;
   bit m_at   = 1'b0;
   bit m_f1   = 1'b0;
   bit m_f2   = 1'b0;

   // per-period mismatch tallies
   int pwm_err  = 0;
   int duty_err = 0;
   int busy_err = 0;
   int at_err   = 0;

   // DUTY change tracking
   int last_duty = 0;
   int prev_duty = 0;
   int first_chg = -1;
   int min_chg   = 999;
   int chg       = 0;
   int off_bnd   = 0;

   fan_pwm_driver #(
      .LOW_DUTY     (LOW),
      .HIGH_DUTY    (HIGH),
      .RAMP_STEP    (STEP),
      .KICK_PERIODS (KICKP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .F1       (F1),
      .F2       (F2),
      .PWM      (PWM),
      .DUTY     (DUTY),
      .BUSY     (BUSY),
      .AT_SPEED (AT_SPEED)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int approach(input int d, input int t);
      if (d < t) return (t - d <= STEP) ? t : d + STEP;
      if (d > t) return (d - t <= STEP) ? t : d - STEP;
      return d;
   endfunction

   task automatic period_check();
      check("period_pwm_cycles_wrong", pwm_err, 0);
      check("period_duty_cycles_wrong", duty_err, 0);
      check("period_busy_cycles_wrong", busy_err, 0);
      check("period_at_speed_cycles_wrong", at_err, 0);
      pwm_err  = 0;
      duty_err = 0;
      busy_err = 0;
      at_err   = 0;
   endtask

   // One clock: advance the model across the edge, then compare just after it
   task automatic cyc();
      int tgt;
      bit bnd;
      @(posedge clk);
      if (rst) begin
         m_cnt = 0; m_duty = 0; m_kick = 0;
         m_pwm = 1'b0; m_busy = 1'b0; m_at = 1'b0; m_f1 = 1'b0; m_f2 = 1'b0;
      end else begin
         tgt   = m_f2 ? HIGH : (m_f1 ? LOW : 0);
         bnd   = (m_cnt == 255);
         m_pwm = (m_duty == 255) || (m_cnt < m_duty);
         if (m_kick > 0 && tgt == 0) begin
            m_kick = 0;
         end else if (bnd) begin
            if (m_kick > 0) begin
               m_kick--;
               if (m_kick == 0) begin
                  m_duty = approach(m_duty, tgt);
                  m_busy = (m_duty != tgt);
               end
            end else if (KICK_EN && !m_busy && m_duty == 0 && tgt != 0) begin
               m_duty = 255;
               m_kick = KICKP;
               m_busy = 1'b1;
            end else begin
               m_duty = approach(m_duty, tgt);
               m_busy = (m_duty != tgt);
            end
         end
         m_at  = (m_duty == tgt) && (tgt != 0);
         m_f1  = F1;
         m_f2  = F2;
         m_cnt = (m_cnt + 1) % 256;
      end
      #1;
      if (PWM !== m_pwm) pwm_err++;
      if (DUTY !== 8'(m_duty)) duty_err++;
      if (BUSY !== m_busy) busy_err++;
      if (AT_SPEED !== m_at) at_err++;
      if (int'(DUTY) != last_duty) begin
         chg++;
         prev_duty = last_duty;
         last_duty = int'(DUTY);
         if (first_chg < 0) first_chg = last_duty;
         if (last_duty < min_chg) min_chg = last_duty;
         if (m_cnt != 0) off_bnd++;
      end
      if (m_cnt == 0) period_check();
   endtask

   task automatic run_periods(input int n);
      for (int i = 0; i < n * 256; i++) cyc();
   endtask

   task automatic measure_high(output int hi);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         cyc();
         if (PWM === 1'b1) hi++;
      end
   endtask

   task automatic clear_track();
      last_duty = int'(DUTY);
      prev_duty = last_duty;
      first_chg = -1;
      min_chg   = 999;
      chg       = 0;
      off_bnd   = 0;
   endtask

   initial begin
      int hi;
      int len;

      rst = 1'b1;
      cyc();
      cyc();
      check("reset_duty", DUTY, 0);
      check("reset_pwm", PWM, 0);
      check("reset_busy", BUSY, 0);
      check("reset_at_speed", AT_SPEED, 0);
      rst = 1'b0;

      // low speed from idle
      clear_track();
      F1 = 1'b1;
      run_periods(30);
      check("low_duty", DUTY, LOW);
      check("low_at_speed", AT_SPEED, 1);
      check("low_busy", BUSY, 0);
      measure_high(hi);
      check("low_pwm_high_cycles", hi, LOW);
`ifdef FAN_KICKSTART_EN
      check("kick_first_duty", first_chg, 255);
      check("kick_min_duty", min_chg, LOW);
      check("kick_duty_changes", chg, 21);
`else
      check("ramp_first_duty", first_chg, STEP);
      check("ramp_duty_changes", chg, LOW / STEP);
`endif

      // reset while ramping down through 40
      F1 = 1'b0;
      for (int i = 0; i < 4096 && DUTY !== 8'd40; i++) cyc();
      check("reach_duty_40", DUTY, 40);
      check("ramp_busy", BUSY, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midramp_rst_duty", DUTY, 0);
      check("midramp_rst_pwm", PWM, 0);
      check("midramp_rst_busy", BUSY, 0);
      check("midramp_rst_at_speed", AT_SPEED, 0);

      F1 = 1'b1;
      run_periods(30);
      check("relaunch_duty", DUTY, LOW);

      // low -> high, final step saturates
      clear_track();
      F2 = 1'b1;
      run_periods(25);
      check("high_duty", DUTY, HIGH);
      check("high_prev_step", prev_duty, 248);
      check("high_at_speed", AT_SPEED, 1);
      measure_high(hi);
      check("high_pwm_high_cycles", hi, 256);

      // high -> off
      F1 = 1'b0;
      F2 = 1'b0;
      run_periods(40);
      check("stop_duty", DUTY, 0);
      check("stop_busy", BUSY, 0);
      check("stop_pwm", PWM, 0);
      measure_high(hi);
      check("stop_pwm_high_cycles", hi, 0);

      // fast F1 toggling: duty may only move at boundaries
      clear_track();
      for (int i = 0; i < 12 * 256; i++) begin
         if (i % 10 == 0) F1 = ~F1;
         cyc();
      end
      check("toggle_offboundary_changes", off_bnd, 0);

      // random request activity against the model
      for (int s = 0; s < 24; s++) begin
         F1  = 1'($urandom_range(0, 1));
         F2  = ($urandom_range(0, 3) == 0);
         len = int'($urandom_range(1, 700));
         for (int i = 0; i < len; i++) cyc();
      end
      run_periods(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
